// File: rtl/mcc_sched_pkg.sv
`default_nettype none
// ============================================================================
// mcc_sched_pkg : shared FSM encoding and width helper for mcc_add_scheduler
// Rev 1.0
// ============================================================================
package mcc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcc_adder.sv
`default_nettype none
// ============================================================================
// mcc_adder : unsigned N-bit adder with carry out
// Rev 1.0
// ============================================================================
module mcc_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule
`default_nettype wire

// File: rtl/mcc_sched_arb.sv
`default_nettype none
// ============================================================================
// mcc_sched_arb : one-hot grant + encoded id; round-robin when MCC_SCHED_RR_EN
//                 is defined, otherwise fixed priority (lowest index wins)
// Rev 1.0
// ============================================================================
module mcc_sched_arb
  import mcc_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        i_req_valid,
`ifdef MCC_SCHED_RR_EN
  input  logic [clog2(NREQ)-1:0] i_ptr,
`endif
  output logic [NREQ-1:0]        o_grant,
  output logic [clog2(NREQ)-1:0] o_gid,
  output logic                   o_any
);

  localparam int IDW = clog2(NREQ);

  logic [IDW-1:0] w_idx;
`ifdef MCC_SCHED_RR_EN
  logic [IDW:0]   w_wrap;
`endif

  // Scan candidates in priority order; the first valid one wins.
  always_comb begin
    o_grant = '0;
    o_gid   = '0;
    o_any   = 1'b0;
    w_idx   = '0;
`ifdef MCC_SCHED_RR_EN
    w_wrap  = '0;
`endif
    for (int k = 0; k < NREQ; k++) begin
`ifdef MCC_SCHED_RR_EN
      w_wrap = {1'b0, i_ptr} + (IDW+1)'(k);
      if (w_wrap >= (IDW+1)'(NREQ)) w_wrap = w_wrap - (IDW+1)'(NREQ);
      w_idx  = w_wrap[IDW-1:0];
`else
      w_idx  = IDW'(k);
`endif
      if (!o_any && i_req_valid[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_gid          = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mcc_add_scheduler.sv
`default_nettype none
// ============================================================================
// mcc_add_scheduler : time-shares one mcc_adder among NREQ valid/ready
//                     requesters; MCC_SCHED_RR_EN selects round-robin grant
// Rev 1.0
// ============================================================================
module mcc_add_scheduler
  import mcc_sched_pkg::*;
#(
  parameter int N    = 4,
  parameter int NREQ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*N-1:0]      req_a,
  input  logic [NREQ*N-1:0]      req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [clog2(NREQ)-1:0] rsp_id,
  output logic [N-1:0]           rsp_sum,
  output logic                   rsp_cout,
  output logic                   busy
);

  localparam int IDW = clog2(NREQ);

  state_t          r_state, w_next_state;
  logic [N-1:0]    r_a, r_b, r_sum;
  logic [N-1:0]    w_a_sel, w_b_sel, w_sum;
  logic            r_cout, w_cout;
  logic [IDW-1:0]  r_op_id, r_rsp_id, w_gid;
  logic [NREQ-1:0] w_grant;
  logic            w_any, w_accept;
`ifdef MCC_SCHED_RR_EN
  logic [IDW-1:0]  r_ptr;
`endif

  mcc_sched_arb #(.NREQ(NREQ)) u_arb (
    .i_req_valid (req_valid),
`ifdef MCC_SCHED_RR_EN
    .i_ptr       (r_ptr),
`endif
    .o_grant     (w_grant),
    .o_gid       (w_gid),
    .o_any       (w_any)
  );

  mcc_adder #(.N(N)) u_adder (
    .i_a    (r_a),
    .i_b    (r_b),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_a_sel = req_a[i*N +: N];
        w_b_sel = req_b[i*N +: N];
      end
    end
  end

  // A new grant is offered from IDLE, or from RESP in the cycle the response leaves.
  always_comb begin
    w_next_state = r_state;
    req_ready    = '0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any && rst_n) begin
          req_ready    = w_grant;
          w_accept     = 1'b1;
          w_next_state = ADD;
        end
      end
      ADD: w_next_state = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (w_any) begin
            req_ready    = w_grant;
            w_accept     = 1'b1;
            w_next_state = ADD;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op_id  <= '0;
      r_rsp_id <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_a     <= w_a_sel;
        r_b     <= w_b_sel;
        r_op_id <= w_gid;
      end
      if (r_state == ADD) begin
        r_sum    <= w_sum;
        r_cout   <= w_cout;
        r_rsp_id <= r_op_id;
      end
    end
  end

`ifdef MCC_SCHED_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= (w_gid == IDW'(NREQ-1)) ? '0 : w_gid + 1'b1;
    end
  end
`endif

  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mcc_add_scheduler.sv
`default_nettype none
// ============================================================================
// tb_mcc_add_scheduler : vector table, corner sequences and a scoreboard
//                        against a reference arbitration/FSM model
// Rev 1.0
// ============================================================================
module tb_mcc_add_scheduler;

  localparam int N    = 4;
  localparam int NREQ = 4;
`ifdef MCC_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid, rsp_ready, rsp_cout, busy;
  logic [1:0]        rsp_id;
  logic [N-1:0]      rsp_sum;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         req;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       cout;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic [3:0] sum;
    logic       cout;
  } exp_t;

  vec_t vecs [7];
  exp_t sbq [$];
  exp_t mon_e;
  logic [3:0] mon_hs;

  mcc_add_scheduler #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int cyc;
    req_valid = '0;
    rsp_ready = 1'b1;
    cyc = 0;
    while (busy && cyc < 20) begin
      tick();
      cyc++;
    end
    if (busy) check("drain_busy", int'(busy), 0);
  endtask

  function automatic logic [3:0] model_grant(input logic [3:0] v, input int p);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = RR ? (p + k) % NREQ : k;
      if (v[idx]) return 4'(1 << idx);
    end
    return 4'b0;
  endfunction

  // Scoreboard: push on request handshake, pop on response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_hs = req_valid & req_ready;
      if (mon_hs != 4'b0) begin
        check("hs_onehot", $countones(mon_hs), 1);
        for (int i = 0; i < NREQ; i++) begin
          if (mon_hs[i]) begin
            mon_e.id = 2'(i);
            {mon_e.cout, mon_e.sum} = 5'(req_a[i*N +: N]) + 5'(req_b[i*N +: N]);
            sbq.push_back(mon_e);
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_rsp", int'(rsp_valid), 0);
        end else begin
          mon_e = sbq.pop_front();
          check("sb_id",   int'(rsp_id),   int'(mon_e.id));
          check("sb_sum",  int'(rsp_sum),  int'(mon_e.sum));
          check("sb_cout", int'(rsp_cout), int'(mon_e.cout));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    int m_state;
    int m_ptr;
    logic [3:0] eg;
    logic ok;

    vecs[0] = '{0, 4'd3,  4'd5,  4'd8,  1'b0};
    vecs[1] = '{0, 4'd15, 4'd1,  4'd0,  1'b1};
    vecs[2] = '{0, 4'd15, 4'd15, 4'd14, 1'b1};
    vecs[3] = '{2, 4'd9,  4'd6,  4'd15, 1'b0};
    vecs[4] = '{3, 4'd8,  4'd8,  4'd0,  1'b1};
    vecs[5] = '{1, 4'd0,  4'd0,  4'd0,  1'b0};
    vecs[6] = '{1, 4'd12, 4'd7,  4'd3,  1'b1};

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_id",    int'(rsp_id),    0);
    check("rst_rsp_sum",   int'(rsp_sum),   0);
    check("rst_rsp_cout",  int'(rsp_cout),  0);
    check("rst_busy",      int'(busy),      0);
    check("rst_req_ready", int'(req_ready), 0);
    rst_n = 1'b1;
    tick();

    // Fairness with all requesters continuously valid.
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = 4'(i);
      req_b[i*N +: N] = 4'd1;
    end
    req_valid = 4'hF;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        check("fair_id", int'(rsp_id), RR ? (n % NREQ) : 0);
        n++;
      end
      tick();
    end
    check("fair_count", n, 5);
    drain();

    // Async reset while the adder stage holds req1's operands.
    req_a[7:4] = 4'd7; req_b[7:4] = 4'd2; req_valid = 4'b0010; rsp_ready = 1'b1;
    @(negedge clk);
    check("rstadd_grant", int'(req_ready), 2);
    tick();
    req_valid = '0;
    check("rstadd_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstadd_rsp_valid", int'(rsp_valid), 0);
    check("rstadd_busy0",     int'(busy),      0);
    check("rstadd_sum",       int'(rsp_sum),   0);
    sbq.delete();
    tick(); tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
      tick();
    end
    check("rstadd_no_rsp", seen, 0);
    req_valid = 4'hF;
    @(negedge clk);
    check("rstadd_ptr_grant", int'(req_ready), 1);
    tick();
    drain();

    // Vector table: single requester, latency and arithmetic.
    for (int t = 0; t < 7; t++) begin
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      req_a[vecs[t].req*N +: N] = vecs[t].a;
      req_b[vecs[t].req*N +: N] = vecs[t].b;
      req_valid = 4'(1 << vecs[t].req);
      rsp_ready = 1'b1;
      @(negedge clk);
      check("tbl_grant", int'(req_ready), 1 << vecs[t].req);
      tick();
      req_valid = '0;
      @(negedge clk);
      check("tbl_lat_not_yet", int'(rsp_valid), 0);
      tick();
      @(negedge clk);
      check("tbl_rsp_valid", int'(rsp_valid), 1);
      check("tbl_rsp_id",    int'(rsp_id),    vecs[t].req);
      check("tbl_rsp_sum",   int'(rsp_sum),   int'(vecs[t].sum));
      check("tbl_rsp_cout",  int'(rsp_cout),  int'(vecs[t].cout));
      tick();
    end

    // Back-pressure: response held, no grant, then grant on release.
    req_a[11:8] = 4'd10; req_b[11:8] = 4'd3;
    req_a[3:0]  = 4'd4;  req_b[3:0]  = 4'd4;
    req_valid = 4'b0100; rsp_ready = 1'b0;
    tick();
    req_valid = 4'b0001;
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rsp_valid", int'(rsp_valid), 1);
      check("bp_rsp_id",    int'(rsp_id),    2);
      check("bp_rsp_sum",   int'(rsp_sum),   13);
      check("bp_rsp_cout",  int'(rsp_cout),  0);
      check("bp_req_ready", int'(req_ready), 0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_grant", int'(req_ready), 1);
    tick();
    drain();
    check("sb_empty_pre_rand", sbq.size(), 0);

    // Random valid/ready against the reference model.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_state = 0;
    m_ptr   = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid = 4'($urandom);
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      ok = (m_state == 0) || (m_state == 2 && rsp_ready);
      eg = ok ? model_grant(req_valid, m_ptr) : 4'b0;
      check("rnd_req_ready", int'(req_ready), int'(eg));
      check("rnd_rsp_valid", int'(rsp_valid), int'(m_state == 2));
      case (m_state)
        0: m_state = (req_valid != 4'b0) ? 1 : 0;
        1: m_state = 2;
        default: if (rsp_ready) m_state = (req_valid != 4'b0) ? 1 : 0;
      endcase
      for (int k = 0; k < NREQ; k++) begin
        if (eg[k]) m_ptr = (k + 1) % NREQ;
      end
      tick();
    end
    drain();
    @(negedge clk);
    check("sb_empty_end", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
